// File: rtl/banco_registradores_pkg.sv
// Shared constants for the register file, also imported by the ALU and the control unit.
package banco_registradores_pkg;

    parameter int unsigned LARGURA_PADRAO       = 32;
    parameter int unsigned BITS_ENDERECO_PADRAO = 5;
    parameter int unsigned REG_ZERO             = 0;
    parameter int unsigned NUM_REGS             = 2 ** BITS_ENDERECO_PADRAO;

endpackage

// File: rtl/porta_leitura.sv
// One registered read port: register-zero check, write-first bypass and hold while le=0.
module porta_leitura
    import banco_registradores_pkg::*;
#(
    parameter int unsigned LARGURA       = LARGURA_PADRAO,
    parameter int unsigned BITS_ENDERECO = BITS_ENDERECO_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        le,
    input  logic [BITS_ENDERECO-1:0]    endereco,
    input  logic                        escreve_reg,
    input  logic [BITS_ENDERECO-1:0]    endereco_escrita,
    input  logic signed [LARGURA-1:0]   dado_escrita,
    input  logic signed [LARGURA-1:0]   dado_armazenado,
    output logic signed [LARGURA-1:0]   dado
);

    logic signed [LARGURA-1:0] dado_d, dado_q;

    // Register zero wins over the bypass, so a write to r0 never leaks out.
    always_comb begin
        dado_d = dado_q;
        if (le) begin
            if (endereco == BITS_ENDERECO'(REG_ZERO)) begin
                dado_d = '0;
            end else if (escreve_reg && (endereco_escrita == endereco)) begin
                dado_d = dado_escrita;
            end else begin
                dado_d = dado_armazenado;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dado_q <= '0;
        end else begin
            dado_q <= dado_d;
        end
    end

    assign dado = dado_q;

endmodule

// File: rtl/banco_registradores.sv
// 2^BITS_ENDERECO x LARGURA register file with two registered read ports, one write port
// and an N/Z flags register. Register 0 always reads as zero.
module banco_registradores
    import banco_registradores_pkg::*;
#(
    parameter int unsigned LARGURA       = LARGURA_PADRAO,
    parameter int unsigned BITS_ENDERECO = BITS_ENDERECO_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        le,
    input  logic [BITS_ENDERECO-1:0]    endereco_X,
    input  logic [BITS_ENDERECO-1:0]    endereco_Y,
    output logic signed [LARGURA-1:0]   var_X,
    output logic signed [LARGURA-1:0]   var_Y,
    input  logic                        escreve_reg,
    input  logic [BITS_ENDERECO-1:0]    endereco_escrita,
    input  logic signed [LARGURA-1:0]   dado_escrita,
    input  logic                        escreve_flags,
    input  logic                        flag_N,
    input  logic                        flag_Z,
    output logic                        flag_N_reg,
    output logic                        flag_Z_reg
);

    localparam int unsigned NUM_ENTRADAS = 2 ** BITS_ENDERECO;

    logic signed [LARGURA-1:0] regs_q [NUM_ENTRADAS];
    logic                      flag_n_q, flag_z_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_ENTRADAS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (escreve_reg && (endereco_escrita != BITS_ENDERECO'(REG_ZERO))) begin
            regs_q[endereco_escrita] <= dado_escrita;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else if (escreve_flags) begin
            flag_n_q <= flag_N;
            flag_z_q <= flag_Z;
        end
    end

    assign flag_N_reg = flag_n_q;
    assign flag_Z_reg = flag_z_q;

    porta_leitura #(
        .LARGURA       (LARGURA),
        .BITS_ENDERECO (BITS_ENDERECO)
    ) u_porta_x (
        .clock            (clock),
        .reset            (reset),
        .le               (le),
        .endereco         (endereco_X),
        .escreve_reg      (escreve_reg),
        .endereco_escrita (endereco_escrita),
        .dado_escrita     (dado_escrita),
        .dado_armazenado  (regs_q[endereco_X]),
        .dado             (var_X)
    );

    porta_leitura #(
        .LARGURA       (LARGURA),
        .BITS_ENDERECO (BITS_ENDERECO)
    ) u_porta_y (
        .clock            (clock),
        .reset            (reset),
        .le               (le),
        .endereco         (endereco_Y),
        .escreve_reg      (escreve_reg),
        .endereco_escrita (endereco_escrita),
        .dado_escrita     (dado_escrita),
        .dado_armazenado  (regs_q[endereco_Y]),
        .dado             (var_Y)
    );

endmodule

// File: tb/tb_banco_registradores.sv
// Scoreboard bench for banco_registradores: directed cases followed by random traffic.
module tb_banco_registradores;
    import banco_registradores_pkg::*;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        n;
        logic        z;
    } esperado_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        le = 1'b0;
    logic [4:0]  endereco_X = '0;
    logic [4:0]  endereco_Y = '0;
    logic [31:0] var_X;
    logic [31:0] var_Y;
    logic        escreve_reg = 1'b0;
    logic [4:0]  endereco_escrita = '0;
    logic [31:0] dado_escrita = '0;
    logic        escreve_flags = 1'b0;
    logic        flag_N = 1'b0;
    logic        flag_Z = 1'b0;
    logic        flag_N_reg;
    logic        flag_Z_reg;

    int testes = 0;
    int falhas = 0;

    esperado_t fila[$];

    // Reference model state: architectural contents and visible outputs.
    logic [31:0] m_mem [NUM_REGS];
    logic [31:0] m_x, m_y;
    logic        m_n, m_z;

    always #5 clock = ~clock;

    banco_registradores dut (
        .clock            (clock),
        .reset            (reset),
        .le               (le),
        .endereco_X       (endereco_X),
        .endereco_Y       (endereco_Y),
        .var_X            (var_X),
        .var_Y            (var_Y),
        .escreve_reg      (escreve_reg),
        .endereco_escrita (endereco_escrita),
        .dado_escrita     (dado_escrita),
        .escreve_flags    (escreve_flags),
        .flag_N           (flag_N),
        .flag_Z           (flag_Z),
        .flag_N_reg       (flag_N_reg),
        .flag_Z_reg       (flag_Z_reg)
    );

    task automatic verifica(input string nome, input logic [31:0] atual,
                            input logic [31:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [31:0] leitura_modelo(input logic [4:0] a, input logic w,
                                                   input logic [4:0] aw, input logic [31:0] d);
        if (a == 5'd0) return 32'd0;
        if (w && aw == a) return d;
        return m_mem[a];
    endfunction

    // Drive one cycle of inputs and push what the outputs must show after the next edge.
    task automatic ciclo(input logic r, input logic l, input logic [4:0] ax,
                         input logic [4:0] ay, input logic w, input logic [4:0] aw,
                         input logic [31:0] d, input logic f, input logic fn, input logic fz);
        esperado_t e;
        @(negedge clock);
        reset = r; le = l; endereco_X = ax; endereco_Y = ay;
        escreve_reg = w; endereco_escrita = aw; dado_escrita = d;
        escreve_flags = f; flag_N = fn; flag_Z = fz;
        if (r) begin
            for (int i = 0; i < int'(NUM_REGS); i++) m_mem[i] = 32'd0;
            m_x = 0; m_y = 0; m_n = 0; m_z = 0;
        end else begin
            if (l) begin
                m_x = leitura_modelo(ax, w, aw, d);
                m_y = leitura_modelo(ay, w, aw, d);
            end
            if (f) begin
                m_n = fn;
                m_z = fz;
            end
            if (w && aw != 5'd0) m_mem[aw] = d;
        end
        e.x = m_x; e.y = m_y; e.n = m_n; e.z = m_z;
        fila.push_back(e);
    endtask

    // Monitor: one expected entry per edge, compared shortly after that edge.
    initial begin
        esperado_t e;
        forever begin
            @(posedge clock);
            if (fila.size() != 0) begin
                e = fila.pop_front();
                #2;
                verifica("var_X", var_X, e.x);
                verifica("var_Y", var_Y, e.y);
                verifica("flag_N_reg", {31'd0, flag_N_reg}, {31'd0, e.n});
                verifica("flag_Z_reg", {31'd0, flag_Z_reg}, {31'd0, e.z});
            end
        end
    end

    initial begin
        int espera;
        // Reset
        ciclo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ciclo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ciclo(0, 0, 0, 0, 1, 5, 32'h12345678, 1, 1, 1);
        ciclo(1, 1, 5, 5, 1, 6, 32'h11111111, 1, 1, 1);
        ciclo(0, 1, 5, 6, 0, 0, 0, 0, 0, 0);
        // Basic write/read
        ciclo(0, 0, 0, 0, 1, 3, 32'hFFFFFFFE, 0, 0, 0);
        ciclo(0, 0, 0, 0, 1, 4, 32'd7, 0, 0, 0);
        ciclo(0, 1, 3, 4, 0, 0, 0, 0, 0, 0);
        // Register zero, same-cycle and later
        ciclo(0, 1, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        ciclo(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Bypass
        ciclo(0, 0, 0, 0, 1, 9, 32'd1, 0, 0, 0);
        ciclo(0, 1, 9, 9, 1, 9, 32'hA5A5A5A5, 0, 0, 0);
        ciclo(0, 1, 9, 4, 0, 0, 0, 0, 0, 0);
        // Hold
        ciclo(0, 0, 1, 2, 1, 3, 32'd9, 0, 0, 0);
        ciclo(0, 1, 3, 3, 0, 0, 0, 0, 0, 0);
        // Flags: capture, hold, capture discarded by reset
        ciclo(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        ciclo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        ciclo(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        ciclo(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        // Random traffic; narrow address range half the time to provoke bypass hits
        for (int k = 0; k < 400; k++) begin
            logic [4:0] mask;
            mask = ($urandom_range(0, 1) == 0) ? 5'h07 : 5'h1F;
            ciclo(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  5'($urandom) & mask, 5'($urandom) & mask,
                  ($urandom_range(0, 2) != 0), 5'($urandom) & mask, $urandom,
                  ($urandom_range(0, 1) == 1), 1'($urandom), 1'($urandom));
        end
        ciclo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        espera = 0;
        while (fila.size() != 0 && espera < 10) begin
            @(negedge clock);
            espera++;
        end
        if (fila.size() != 0) begin
            falhas++;
            $display("FAIL drain: got %0d pending, expected 0", fila.size());
        end
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
